// File: rtl/if_id_buffer_pkg.sv
`default_nettype none
//==============================================================================
// Module      : if_id_buffer_pkg
// Description : Shared definitions for the IF/ID boundary stage: the bubble
//               instruction word, the FIFO entry layout and the legal range
//               of FIFO depths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package if_id_buffer_pkg;

   // addi x0, x0, 0 -- the canonical RISC-V NOP, presented on a bubble
   localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

   // Legal FIFO depth range
   localparam int C_DEPTH_MIN = 2;
   localparam int C_DEPTH_MAX = 8;

   // One buffered fetch: the instruction and the PC it was fetched from
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage : if_id_buffer_pkg
`default_nettype wire

// File: rtl/if_id_buffer_if_fifo.sv
`default_nettype none
//==============================================================================
// Module      : if_fifo
// Description : Synchronous first-word-fall-through FIFO of fetch entries.
//               Pointers wrap modulo DEPTH, so any depth in range works, not
//               only powers of two. A push on a full FIFO is accepted only
//               when a pop happens in the same cycle.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               clr        - synchronous clear (empties the FIFO)
//               push, din  - write request and entry
//               pop        - read request (ignored when empty)
//               dout       - head entry (valid whenever !empty)
//               count      - number of stored entries, 0..DEPTH
//               full, empty- status flags
// Revision    : 1.0 - initial release
//==============================================================================
module if_fifo
   import if_id_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  fetch_entry_t  din,
   output fetch_entry_t  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_do_pop;
   logic          w_do_push;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [PW-1:0] w_rd_ptr_nxt;

   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rd_ptr];

   // A pop frees the head slot this cycle, so a full FIFO may still accept
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_do_pop)  r_rd_ptr <= w_rd_ptr_nxt;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy is tracked by r_count alone
   always_ff @(posedge clk) begin
      if (!rst && !clr && w_do_push) r_mem[r_wr_ptr] <= din;
   end

endmodule : if_fifo
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
//==============================================================================
// Module      : if_id_buffer
// Description : IF/ID boundary register. Captures instructions returned by
//               the instruction memory with their PC and presents one
//               registered instruction per cycle to decode. Beats arriving
//               while decode is paused (or while older beats are queued)
//               go through a small FIFO; otherwise they bypass straight into
//               the ID register. fetch_hold throttles the PC so the FIFO
//               always has room for the one in-flight response.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               imem_rvalid/pc/rdata- returned instruction beat
//               pause               - hold the ID register
//               flush               - discard everything held or arriving
//               id_valid/pc/pc4/instr - ID register outputs
//               fetch_hold          - pause request to the PC
//               overflow_err        - sticky: push attempted on a full FIFO
// Revision    : 1.0 - initial release
//==============================================================================
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_pc,
   input  logic [31:0] imem_rdata,
   input  logic        pause,
   input  logic        flush,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_instr,
   output logic        fetch_hold,
   output logic        overflow_err
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t  w_beat;
   fetch_entry_t  w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   logic          r_valid;
   logic [31:0]   r_pc;
   logic [31:0]   r_pc4;
   logic [31:0]   r_instr;
   logic          r_overflow;

   assign w_beat.pc    = imem_pc;
   assign w_beat.instr = imem_rdata;

   // Queued beats must drain first to keep arrival order, so a beat only
   // bypasses the FIFO when it is empty and decode is advancing.
   assign w_pop  = !flush && !pause && !w_empty;
   assign w_push = imem_rvalid && !flush && (pause || !w_empty);

   if_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_beat),
      .dout  (w_head),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   // Hold one slot early: the PC register still has one response in flight
   assign fetch_hold = (w_count >= CW'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_pc       <= 32'd0;
         r_pc4      <= 32'd4;
         r_instr    <= NOP_INSTR;
         r_overflow <= 1'b0;
      end else begin
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;

         if (flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
         end else if (!pause) begin
            if (!w_empty) begin
               r_valid <= 1'b1;
               r_pc    <= w_head.pc;
               r_pc4   <= w_head.pc + 32'd4;
               r_instr <= w_head.instr;
            end else if (imem_rvalid) begin
               r_valid <= 1'b1;
               r_pc    <= imem_pc;
               r_pc4   <= imem_pc + 32'd4;
               r_instr <= imem_rdata;
            end else begin
               r_valid <= 1'b0;
               r_instr <= NOP_INSTR;
            end
         end
      end
   end

   assign id_valid     = r_valid;
   assign id_pc        = r_pc;
   assign id_pc4       = r_pc4;
   assign id_instr     = r_instr;
   assign overflow_err = r_overflow;

endmodule : if_id_buffer
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
//==============================================================================
// Module      : tb_if_id_buffer
// Description : Self-checking bench for if_id_buffer. A queue-based model of
//               the buffer tracks expected ID contents, occupancy and the
//               overflow flag; every stimulus step compares all outputs.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_if_id_buffer;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_rvalid;
   logic [31:0] imem_pc;
   logic [31:0] imem_rdata;
   logic        pause;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_instr;
   logic        fetch_hold;
   logic        overflow_err;

   if_id_buffer #(
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_rvalid  (imem_rvalid),
      .imem_pc      (imem_pc),
      .imem_rdata   (imem_rdata),
      .pause        (pause),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_pc4       (id_pc4),
      .id_instr     (id_instr),
      .fetch_hold   (fetch_hold),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   // Reference model state
   ent_t        q[$];
   logic        m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic        m_err;

   int total  = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance the model by one edge according to the buffer's rules
   task automatic model(input logic r, input logic rv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic p, input logic f);
      ent_t e;
      if (r) begin
         q.delete();
         m_valid = 1'b0; m_pc = 32'd0; m_instr = NOP; m_err = 1'b0;
      end else if (f) begin
         q.delete();
         m_valid = 1'b0; m_instr = NOP;
      end else if (p) begin
         if (rv) begin
            if (q.size() < DEPTH) q.push_back('{pc, ins});
            else m_err = 1'b1;
         end
      end else if (q.size() > 0) begin
         e = q.pop_front();
         if (rv) q.push_back('{pc, ins});
         m_valid = 1'b1; m_pc = e.pc; m_instr = e.instr;
      end else if (rv) begin
         m_valid = 1'b1; m_pc = pc; m_instr = ins;
      end else begin
         m_valid = 1'b0; m_instr = NOP;
      end
   endtask

   // Drive one cycle of inputs, clock it, then compare every output
   task automatic step(input logic r, input logic rv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic p, input logic f);
      rst = r; imem_rvalid = rv; imem_pc = pc; imem_rdata = ins; pause = p; flush = f;
      model(r, rv, pc, ins, p, f);
      @(posedge clk);
      #1;
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("id_instr", id_instr, m_instr);
      if (m_valid) begin
         chk("id_pc", id_pc, m_pc);
         chk("id_pc4", id_pc4, m_pc + 32'd4);
      end
      chk("fetch_hold", {31'd0, fetch_hold}, {31'd0, (q.size() >= DEPTH - 1)});
      chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_err});
   endtask

   initial begin
      logic rv, p, f;
      logic [31:0] pcr;

      rst = 1'b1; imem_rvalid = 1'b0; imem_pc = '0; imem_rdata = '0; pause = 1'b0; flush = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      chk("reset id_pc", id_pc, 32'd0);
      chk("reset id_pc4", id_pc4, 32'd4);

      // In-order bypass stream, one per cycle
      step(0, 1, 32'h0, 32'hAAAA_0001, 0, 0);
      step(0, 1, 32'h4, 32'hBBBB_0002, 0, 0);
      step(0, 1, 32'h8, 32'hCCCC_0003, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Pause while two beats arrive, then drain
      step(0, 1, 32'h3C, 32'h1111_0000, 0, 0);
      step(0, 1, 32'h10, 32'h1111_0010, 1, 0);
      step(0, 1, 32'h14, 32'h1111_0014, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Flush together with pause, a beat and two buffered entries
      step(0, 1, 32'h20, 32'h2222_0020, 0, 0);
      step(0, 1, 32'h24, 32'h2222_0024, 1, 0);
      step(0, 1, 32'h28, 32'h2222_0028, 1, 0);
      step(0, 1, 32'h2C, 32'h2222_002C, 1, 1);
      step(0, 0, 0, 0, 0, 0);

      // Overflow: extra beat with FIFO full and paused
      step(0, 1, 32'h40, 32'h3333_0040, 1, 0);
      step(0, 1, 32'h44, 32'h3333_0044, 1, 0);
      step(0, 1, 32'h48, 32'h3333_0048, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // PC wrap on pc4
      step(0, 1, 32'hFFFF_FFFC, 32'h4444_4444, 0, 0);
      chk("wrap id_pc4", id_pc4, 32'h0);

      // Reset while full with a valid ID, then a bypass beat
      step(0, 1, 32'h50, 32'h5555_0050, 1, 0);
      step(0, 1, 32'h54, 32'h5555_0054, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("rst id_pc", id_pc, 32'd0);
      chk("rst id_pc4", id_pc4, 32'd4);
      step(0, 1, 32'h60, 32'h6666_0060, 0, 0);

      // Randomised traffic; beats withheld only when the FIFO is full
      for (int i = 0; i < 400; i++) begin
         p   = ($urandom_range(0, 9) < 3);
         f   = ($urandom_range(0, 19) == 0);
         rv  = ($urandom_range(0, 9) < 6) && (q.size() < DEPTH);
         pcr = $urandom() & 32'hFFFF_FFFC;
         step(0, rv, pcr, $urandom(), p, f);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule : tb_if_id_buffer
`default_nettype wire
